// File: rtl/keypad_calc_core.sv
// keypad_calc_core: hex-entry chained integer calculator fed by keypad tokens over valid/ready
module keypad_calc_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_display,
  output logic             o_error,
  output logic             o_busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] S_A = 2'd0, S_B = 2'd1, S_DIV = 2'd2, S_ERR = 2'd3;
  logic [1:0]       state;
  logic [WIDTH-1:0] acc, a_reg, rem, quo;
  logic [2:0]       op_reg, pend_op;
  logic             pend_eq, fresh;
  logic [CW-1:0]    cnt;
  logic             fire, is_dig, is_ac, is_eq, is_op, eval, done, apply, ge, a_eq;
  logic [2:0]       a_op;
  logic [WIDTH-1:0] shifted, arith, rem_n, quo_n, res;
  logic [WIDTH:0]   r2, diff;
  assign o_ready = state != S_DIV;
  assign o_busy  = state == S_DIV;
  assign fire    = i_valid && o_ready;
  assign is_dig  = !i_data[4];
  assign is_ac   = i_data == 5'b10000;
  assign is_eq   = i_data == 5'b10101;
  assign is_op   = i_data[4:3] == 2'b10 && i_data[2:0] != 3'd0 && i_data[2:0] <= 3'd4;
  assign shifted = fresh ? {{(WIDTH-4){1'b0}}, i_data[3:0]} : {acc[WIDTH-5:0], i_data[3:0]};
  assign arith   = op_reg == 3'd1 ? a_reg + acc : op_reg == 3'd2 ? a_reg - acc : a_reg * acc;
  assign r2      = {rem, quo[WIDTH-1]};
  assign diff    = r2 - {1'b0, acc};
  assign ge      = r2 >= {1'b0, acc};
  assign rem_n   = ge ? diff[WIDTH-1:0] : r2[WIDTH-1:0];
  assign quo_n   = {quo[WIDTH-2:0], ge};
  assign eval    = fire && state == S_B && (is_eq || is_op);
  assign done    = state == S_DIV && cnt == LAST;
  assign apply   = (eval && op_reg != 3'd4) || done;
  assign res     = done ? quo_n : arith;
  assign a_eq    = done ? pend_eq : is_eq;
  assign a_op    = done ? pend_op : i_data[2:0];
  always_ff @(posedge clk)
    if (rst || (fire && is_ac)) begin
      state     <= S_A;
      acc       <= '0;
      a_reg     <= '0;
      op_reg    <= 3'd1;
      fresh     <= 1'b0;
      o_display <= '0;
      o_error   <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      pend_eq   <= 1'b0;
      pend_op   <= 3'd1;
    end else if (apply) begin
      o_display <= res;
      state     <= a_eq ? S_A : S_B;
      acc       <= a_eq ? res : '0;
      fresh     <= a_eq;
      if (!a_eq) begin
        a_reg  <= res;
        op_reg <= a_op;
      end
    end else if (state == S_DIV) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + 1'b1;
    end else if (fire && is_dig && state != S_ERR) begin
      acc       <= shifted;
      fresh     <= 1'b0;
      o_display <= shifted;
    end else if (fire && is_op && state == S_A) begin
      a_reg     <= acc;
      op_reg    <= i_data[2:0];
      acc       <= '0;
      fresh     <= 1'b0;
      o_display <= acc;
      state     <= S_B;
    end else if (eval) begin
      if (acc == '0) begin
        state     <= S_ERR;
        o_error   <= 1'b1;
        o_display <= '0;
      end else begin
        state   <= S_DIV;
        rem     <= '0;
        quo     <= a_reg;
        cnt     <= '0;
        pend_eq <= is_eq;
        pend_op <= i_data[2:0];
      end
    end
endmodule

// File: tb/tb_keypad_calc_core.sv
// tb_keypad_calc_core: directed and randomized checks of keypad_calc_core against a token-level calculator model
module tb_keypad_calc_core;
  localparam int W = 8;
  localparam logic [4:0] AC = 5'd16, ADD = 5'd17, SUB = 5'd18, MUL = 5'd19, DIV = 5'd20, EQ = 5'd21;
  logic         clk = 0, rst = 1, i_valid = 0, o_ready, o_error, o_busy;
  logic [4:0]   i_data = 0;
  logic [W-1:0] o_display;
  int total = 0, bad = 0, busy_cycles = 0;
  int           mst, mop, mexp_busy;
  logic [W-1:0] macc, ma, mdisp;
  bit           mfresh, merr;

  keypad_calc_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_display(o_display), .o_error(o_error), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mst = 0; mop = ADD; macc = 0; ma = 0; mdisp = 0; mfresh = 0; merr = 0; mexp_busy = 0;
  endtask

  task automatic model_eval(input int t);
    logic [W-1:0] r;
    if (mop == DIV && macc == 0) begin
      mst = 2; merr = 1; mdisp = 0;
      return;
    end
    if (mop == DIV) mexp_busy = W;
    r = mop == ADD ? ma + macc : mop == SUB ? ma - macc : mop == MUL ? ma * macc : ma / macc;
    mdisp = r;
    if (t == EQ) begin
      macc = r; mfresh = 1; mst = 0;
    end else begin
      ma = r; macc = 0; mop = t; mst = 1;
    end
  endtask

  task automatic model(input int t);
    mexp_busy = 0;
    if (t == AC) model_clear();
    else if (mst == 2) ;
    else if (t < 16) begin
      macc = mfresh ? W'(t) : W'((macc << 4) | t);
      mfresh = 0; mdisp = macc;
    end else if (t >= ADD && t <= DIV) begin
      if (mst == 0) begin
        ma = macc; mop = t; macc = 0; mdisp = ma; mfresh = 0; mst = 1;
      end else model_eval(t);
    end else if (t == EQ && mst == 1) model_eval(t);
  endtask

  task automatic xfer(input logic [4:0] t);
    int n = 0;
    @(negedge clk);
    i_data = t; i_valid = 1;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL ready_timeout got=%b exp=1", o_ready);
    end
    @(posedge clk); #1;
    i_valid = 0;
    model(t);
  endtask

  task automatic wait_idle();
    busy_cycles = 0;
    while (o_busy && busy_cycles < 100) begin
      @(posedge clk); #1;
      busy_cycles++;
    end
  endtask

  task automatic send(input logic [4:0] t);
    xfer(t);
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk); rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (o_display !== 8'h00 || o_error !== 0 || o_ready !== 1 || o_busy !== 0) begin
      bad++; $display("FAIL reset got=%h/%b/%b/%b exp=00/0/1/0", o_display, o_error, o_ready, o_busy);
    end
    repeat (10) @(negedge clk);
    total++;
    if (o_display !== 8'h00 || o_error !== 0 || o_ready !== 1 || o_busy !== 0) begin
      bad++; $display("FAIL idle got=%h/%b/%b/%b exp=00/0/1/0", o_display, o_error, o_ready, o_busy);
    end
  endtask

  task automatic test_entry();
    send(AC); send(5'd1); send(5'd2);
    total++;
    if (o_display !== 8'h12) begin bad++; $display("FAIL entry12 got=%h exp=12", o_display); end
    send(5'd3);
    total++;
    if (o_display !== 8'h23) begin bad++; $display("FAIL entry_trunc got=%h exp=23", o_display); end
    send(5'b11000);
    total++;
    if (o_display !== 8'h23) begin bad++; $display("FAIL invalid got=%h exp=23", o_display); end
  endtask

  task automatic test_arith();
    send(AC); send(5'd1); send(5'd2); send(ADD); send(5'd5); send(EQ);
    total++;
    if (o_display !== 8'h17) begin bad++; $display("FAIL add got=%h exp=17", o_display); end
    send(5'd7);
    total++;
    if (o_display !== 8'h07) begin bad++; $display("FAIL fresh got=%h exp=07", o_display); end
    send(AC); send(5'd1); send(5'd0); send(MUL); send(5'd2); send(5'd0); send(EQ);
    total++;
    if (o_display !== 8'h00) begin bad++; $display("FAIL mul got=%h exp=00", o_display); end
    send(AC); send(5'd3); send(SUB); send(5'd5); send(EQ);
    total++;
    if (o_display !== 8'hFE) begin bad++; $display("FAIL sub got=%h exp=fe", o_display); end
  endtask

  task automatic test_chain();
    send(AC); send(5'd2); send(ADD); send(5'd3); send(ADD);
    total++;
    if (o_display !== 8'h05) begin bad++; $display("FAIL chain1 got=%h exp=05", o_display); end
    send(5'd4); send(EQ);
    total++;
    if (o_display !== 8'h09) begin bad++; $display("FAIL chain2 got=%h exp=09", o_display); end
  endtask

  task automatic test_divide();
    int n = 0;
    send(AC); send(5'd12); send(5'd8); send(DIV); send(5'd7);
    xfer(EQ);
    i_data = 5'd3; i_valid = 1;
    while (!o_ready && n < 100) begin
      total++;
      if (o_busy !== 1) begin bad++; $display("FAIL div_busy got=%b exp=1", o_busy); end
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != W) begin bad++; $display("FAIL div_cycles got=%0d exp=%0d", n, W); end
    total++;
    if (o_display !== 8'h1C || o_busy !== 0) begin bad++; $display("FAIL div_result got=%h/%b exp=1c/0", o_display, o_busy); end
    @(posedge clk); #1;
    i_valid = 0;
    model(5'd3);
    total++;
    if (o_display !== 8'h03) begin bad++; $display("FAIL held_digit got=%h exp=03", o_display); end
  endtask

  task automatic test_error();
    send(AC); send(5'd5); send(DIV); send(5'd0); send(EQ);
    total++;
    if (o_error !== 1 || o_display !== 8'h00) begin bad++; $display("FAIL dz got=%b/%h exp=1/00", o_error, o_display); end
    send(5'd4);
    total++;
    if (o_error !== 1 || o_display !== 8'h00) begin bad++; $display("FAIL err_ignore got=%b/%h exp=1/00", o_error, o_display); end
    send(AC); send(5'd6);
    total++;
    if (o_error !== 0 || o_display !== 8'h06) begin bad++; $display("FAIL err_clear got=%b/%h exp=0/06", o_error, o_display); end
    send(AC); send(5'd8); send(DIV); send(5'd0); send(ADD);
    total++;
    if (o_error !== 1 || o_display !== 8'h00) begin bad++; $display("FAIL chain_dz got=%b/%h exp=1/00", o_error, o_display); end
  endtask

  task automatic test_reset_mid_div();
    send(AC); send(5'd5); send(DIV); send(5'd3);
    xfer(EQ);
    repeat (3) @(posedge clk);
    do_reset();
    total++;
    if (o_display !== 8'h00 || o_error !== 0 || o_ready !== 1 || o_busy !== 0) begin
      bad++; $display("FAIL mid_rst got=%h/%b/%b/%b exp=00/0/1/0", o_display, o_error, o_ready, o_busy);
    end
    send(5'd1); send(5'd2);
    total++;
    if (o_display !== 8'h12) begin bad++; $display("FAIL post_rst got=%h exp=12", o_display); end
  endtask

  task automatic test_random();
    logic [4:0] t;
    int k;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 99);
      t = k < 50 ? 5'($urandom_range(0, 15)) : k < 80 ? 5'($urandom_range(17, 20)) :
          k < 92 ? EQ : k < 95 ? AC : 5'($urandom_range(22, 31));
      send(t);
      total++;
      if (o_display !== mdisp || o_error !== merr || busy_cycles != mexp_busy || o_ready !== 1) begin
        bad++;
        $display("FAIL rand%0d tok=%0d got=%h/%b/%0d exp=%h/%b/%0d", i, t, o_display, o_error, busy_cycles, mdisp, merr, mexp_busy);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_entry();
    test_arith();
    test_chain();
    test_divide();
    test_error();
    test_reset_mid_div();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
